call_ret_ctrl: RTL and testbench
================================

Name: call_ret_ctrl

Overview:
- Initiator side of the 12-bit, 8-entry return-address stack interface (push/pop/writeData/readData).
- Takes CALL and RET requests from the decode/control unit and sequences the stack push/pop.
- Computes the return address and drives the next-PC load.
- Tracks stack depth, raises sticky overflow/underflow flags, and stalls the datapath via busy while a sequence is in flight.

Parameters:
- ADDR_W, 12: instruction address width; equals the stack data width.
- DEPTH, 8: stack entries; must match the attached stack.
- DEPTH_W, 4: width of the depth counter; must satisfy 2^DEPTH_W > DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- call_req  in  1  level request for CALL; sampled only in IDLE.
- ret_req  in  1  level request for RET; sampled only in IDLE.
- target_addr  in  ADDR_W  CALL target; sampled when a CALL is accepted.
- pc_cur  in  ADDR_W  current PC; sampled when a CALL is accepted.
- stk_push  out  1  push strobe to the stack.
- stk_pop  out  1  pop strobe to the stack.
- stk_wdata  out  ADDR_W  data to push.
- stk_rdata  in  ADDR_W  popped entry; valid in the cycle after stk_pop.
- pc_load  out  1  one-cycle strobe: PC takes pc_next.
- pc_next  out  ADDR_W  new PC value.
- busy  out  1  high in every non-IDLE state; the CPU holds its PC and request lines while busy is high.
- depth  out  DEPTH_W  current number of stack entries.
- overflow  out  1  sticky; CALL was attempted at depth==DEPTH.
- underflow  out  1  sticky; RET was attempted at depth==0.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; depth=0; flags cleared; internal address registers cleared.
- States: IDLE, CALL_PUSH, RET_POP, RET_LOAD.
- IDLE, call_req=1:
  - depth<DEPTH: register ret_addr=pc_cur+1 (modulo 2^ADDR_W, so 0xFFF -> 0x000) and tgt=target_addr; go to CALL_PUSH.
  - depth==DEPTH: set overflow; stay in IDLE; no push, no pc_load.
- IDLE, ret_req=1 and call_req=0:
  - depth>0: go to RET_POP.
  - depth==0: set underflow; stay in IDLE; no pop, no pc_load.
- call_req and ret_req both high in IDLE: CALL wins; the RET is dropped without setting a flag.
- CALL_PUSH (1 cycle): stk_push=1, stk_wdata=ret_addr, pc_load=1, pc_next=tgt; depth+1; then IDLE.
- RET_POP (1 cycle): stk_pop=1; depth-1; then RET_LOAD.
- RET_LOAD (1 cycle): pc_load=1, pc_next=stk_rdata; then IDLE.
- Latency from acceptance edge: CALL completes 1 cycle later; RET completes 2 cycles later.
- Every strobe is a single-cycle pulse. stk_push and stk_pop are never high together.
- stk_wdata and pc_next read 0 whenever their strobe is low.
- Requests arriving while busy=1 are not sampled.
- depth stays within 0..DEPTH; it never wraps, outside the optional mode below.

Optional Feature:
- Macro: CALL_RET_WRAP_EN.
- Defined: a CALL at depth==DEPTH is accepted; it pushes (the stack overwrites circularly), loads the target, leaves depth at DEPTH, and still sets overflow as a warning.
- Not defined: the reject behaviour above.
- RET at depth 0 is identical in both builds.

Decomposition:
- Shared package ca_pkg:
  - ADDR_W and DEPTH constants.
  - crc_state_t enum {IDLE, CALL_PUSH, RET_POP, RET_LOAD}.
- Sub-module stack_depth_ctr: saturating up/down counter with inc, dec, full and empty outputs. It owns the depth register and the boundary compares.

Test Plan:
- Single CALL: reset; pc_cur=0x010, target=0x200, call_req one cycle -> next cycle stk_push=1, stk_wdata=0x011, pc_load=1, pc_next=0x200, depth=1, busy=1 for exactly 1 cycle.
- CALL then RET: following the CALL, stk_rdata model returns 0x011 -> stk_pop one cycle, then pc_load=1, pc_next=0x011 on the next cycle; depth returns to 0.
- Overflow: 8 CALLs then a 9th -> no stk_push, no pc_load, overflow=1 and stays set; depth=8. With CALL_RET_WRAP_EN: push and pc_load occur, depth=8, overflow=1.
- Underflow and wrap: RET after reset -> no stk_pop, underflow=1. Then CALL with pc_cur=0xFFF -> stk_wdata=0x000.
- Collision/busy: call_req and ret_req both high -> only the push sequence runs. A ret_req pulse asserted while busy -> ignored, no stk_pop.
- Reset mid-operation: assert rst during RET_POP -> state IDLE and all outputs/flags 0 immediately; no pc_load afterwards.

Source files
------------

// File: rtl/call_ret_ctrl_pkg.sv
// Shared constants and state encoding for the CALL/RET sequencer.
// Imported by call_ret_ctrl and stack_depth_ctr.
package ca_pkg;

    localparam int ADDR_W  = 12;
    localparam int DEPTH   = 8;
    localparam int DEPTH_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALL_PUSH,
        RET_POP,
        RET_LOAD
    } crc_state_t;

endpackage

// File: rtl/call_ret_ctrl_stack_depth_ctr.sv
// Saturating up/down counter tracking return-stack occupancy.
// Owns the depth register and the full/empty compares.
module stack_depth_ctr
    import ca_pkg::*;
#(
    parameter int DEPTH   = ca_pkg::DEPTH,
    parameter int DEPTH_W = ca_pkg::DEPTH_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               dec,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    logic [DEPTH_W-1:0] r_depth;
    logic               w_full;
    logic               w_empty;

    assign w_full  = (r_depth == DEPTH_W'(DEPTH));
    assign w_empty = (r_depth == '0);

    // Count up on push, down on pop, holding at both ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_depth <= '0;
        end else if (inc && !dec && !w_full) begin
            r_depth <= r_depth + 1'b1;
        end else if (dec && !inc && !w_empty) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    assign depth = r_depth;
    assign full  = w_full;
    assign empty = w_empty;

endmodule

// File: rtl/call_ret_ctrl.sv
// CALL/RET sequencer driving a return-address stack and the PC load.
// Build option CALL_RET_WRAP_EN: accept CALL when full (stack overwrites).
module call_ret_ctrl
    import ca_pkg::*;
#(
    parameter int ADDR_W  = ca_pkg::ADDR_W,
    parameter int DEPTH   = ca_pkg::DEPTH,
    parameter int DEPTH_W = ca_pkg::DEPTH_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               call_req,
    input  logic               ret_req,
    input  logic [ADDR_W-1:0]  target_addr,
    input  logic [ADDR_W-1:0]  pc_cur,
    output logic               stk_push,
    output logic               stk_pop,
    output logic [ADDR_W-1:0]  stk_wdata,
    input  logic [ADDR_W-1:0]  stk_rdata,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               busy,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow,
    output logic               underflow
);

    crc_state_t        r_state;
    crc_state_t        w_next;
    logic [ADDR_W-1:0] r_ret_addr;
    logic [ADDR_W-1:0] r_tgt;
    logic              r_ovf;
    logic              r_unf;

    logic              w_push;
    logic              w_pop;
    logic              w_load;
    logic [ADDR_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_pnext;
    logic              w_accept_call;
    logic              w_set_ovf;
    logic              w_set_unf;
    logic              w_full;
    logic              w_empty;
    logic [DEPTH_W-1:0] w_depth;

    stack_depth_ctr #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_depth (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_push),
        .dec   (w_pop),
        .depth (w_depth),
        .full  (w_full),
        .empty (w_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and strobes; requests are only looked at in IDLE.
    always_comb begin
        w_next        = r_state;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_load        = 1'b0;
        w_wdata       = '0;
        w_pnext       = '0;
        w_accept_call = 1'b0;
        w_set_ovf     = 1'b0;
        w_set_unf     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (call_req) begin
                    if (!w_full) begin
                        w_next        = CALL_PUSH;
                        w_accept_call = 1'b1;
                    end else begin
                        w_set_ovf = 1'b1;
`ifdef CALL_RET_WRAP_EN
                        w_next        = CALL_PUSH;
                        w_accept_call = 1'b1;
`endif
                    end
                end else if (ret_req) begin
                    if (!w_empty) begin
                        w_next = RET_POP;
                    end else begin
                        w_set_unf = 1'b1;
                    end
                end
            end
            CALL_PUSH: begin
                w_push  = 1'b1;
                w_wdata = r_ret_addr;
                w_load  = 1'b1;
                w_pnext = r_tgt;
                w_next  = IDLE;
            end
            RET_POP: begin
                w_pop  = 1'b1;
                w_next = RET_LOAD;
            end
            RET_LOAD: begin
                w_load  = 1'b1;
                w_pnext = stk_rdata;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Capture return address and target when a CALL is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ret_addr <= '0;
            r_tgt      <= '0;
        end else if (w_accept_call) begin
            r_ret_addr <= pc_cur + ADDR_W'(1);
            r_tgt      <= target_addr;
        end
    end

    // Sticky boundary flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_set_ovf) r_ovf <= 1'b1;
            if (w_set_unf) r_unf <= 1'b1;
        end
    end

    assign stk_push  = w_push;
    assign stk_pop   = w_pop;
    assign stk_wdata = w_wdata;
    assign pc_load   = w_load;
    assign pc_next   = w_pnext;
    assign busy      = (r_state != IDLE);
    assign depth     = w_depth;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Scoreboard bench for call_ret_ctrl with a queue-based return-stack model.
// Honors CALL_RET_WRAP_EN to match the DUT build.
module tb_call_ret_ctrl;

    localparam int AW = 12;
    localparam int D  = 8;
`ifdef CALL_RET_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct packed {
        logic          push;
        logic          pop;
        logic          load;
        logic [AW-1:0] wdata;
        logic [AW-1:0] pnext;
    } ev_t;

    logic          clk;
    logic          rst;
    logic          call_req;
    logic          ret_req;
    logic [AW-1:0] target_addr;
    logic [AW-1:0] pc_cur;
    logic          stk_push;
    logic          stk_pop;
    logic [AW-1:0] stk_wdata;
    logic [AW-1:0] stk_rdata;
    logic          pc_load;
    logic [AW-1:0] pc_next;
    logic          busy;
    logic [3:0]    depth;
    logic          overflow;
    logic          underflow;

    call_ret_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .call_req    (call_req),
        .ret_req     (ret_req),
        .target_addr (target_addr),
        .pc_cur      (pc_cur),
        .stk_push    (stk_push),
        .stk_pop     (stk_pop),
        .stk_wdata   (stk_wdata),
        .stk_rdata   (stk_rdata),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .busy        (busy),
        .depth       (depth),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    ev_t           exp_q[$];
    logic [AW-1:0] ras[$];
    int            m_depth;
    bit            m_ovf;
    bit            m_unf;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Attached stack: circular memory, popped data held on stk_rdata.
    logic [AW-1:0] smem[D];
    int            sp;
    initial begin
        sp        = 0;
        stk_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sp = 0;
            end else begin
                if (stk_push) begin
                    smem[sp % D] = stk_wdata;
                    sp++;
                end
                if (stk_pop && sp > 0) begin
                    sp--;
                    stk_rdata = smem[sp % D];
                end
            end
        end
    end

    // Monitor: every strobe cycle must match the next expected event.
    initial begin
        ev_t act;
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("push_pop_excl", 32'(stk_push & stk_pop), 0);
                if (!stk_push) chk("wdata_idle", 32'(stk_wdata), 0);
                if (!pc_load) chk("pc_next_idle", 32'(pc_next), 0);
                if (stk_push || stk_pop || pc_load) begin
                    act = '{stk_push, stk_pop, pc_load, stk_wdata, pc_next};
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_strobe actual=%0h required=none", act);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe_event", 32'(act), 32'(e));
                    end
                end
            end
        end
    end

    task automatic model_reset();
        m_depth = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        ras.delete();
        exp_q.delete();
    endtask

    // Issue one request in IDLE, queue expected events, await completion.
    task automatic do_op(input bit c, input bit r, input logic [AW-1:0] pc,
                         input logic [AW-1:0] tgt, input bit inj);
        int            lat;
        int            n;
        ev_t           e;
        logic [AW-1:0] ra;
        @(negedge clk);
        call_req    = c;
        ret_req     = r;
        pc_cur      = pc;
        target_addr = tgt;
        lat         = 0;
        if (c) begin
            if (m_depth < D || WRAP) begin
                ra = pc + 12'd1;
                ras.push_back(ra);
                if (ras.size() > D) void'(ras.pop_front());
                e = '{1'b1, 1'b0, 1'b1, ra, tgt};
                exp_q.push_back(e);
                lat = 1;
                if (m_depth == D) m_ovf = 1'b1;
                else m_depth++;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (r) begin
            if (m_depth > 0) begin
                e = '{1'b0, 1'b1, 1'b0, 12'h0, 12'h0};
                exp_q.push_back(e);
                ra = ras.pop_back();
                e = '{1'b0, 1'b0, 1'b1, 12'h0, ra};
                exp_q.push_back(e);
                lat = 2;
                m_depth--;
            end else begin
                m_unf = 1'b1;
            end
        end
        @(negedge clk);
        call_req = 1'b0;
        ret_req  = 1'b0;
        n = 0;
        while (busy && n < 6) begin
            ret_req = inj;
            @(negedge clk);
            n++;
        end
        ret_req = 1'b0;
        chk("busy_cycles", 32'(n), 32'(lat));
        chk("depth", 32'(depth), 32'(m_depth));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_push"}, 32'(stk_push), 0);
        chk({tag, "_pop"}, 32'(stk_pop), 0);
        chk({tag, "_load"}, 32'(pc_load), 0);
        chk({tag, "_wdata"}, 32'(stk_wdata), 0);
        chk({tag, "_pnext"}, 32'(pc_next), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_depth"}, 32'(depth), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_unf"}, 32'(underflow), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        call_req    = 1'b0;
        ret_req     = 1'b0;
        pc_cur      = '0;
        target_addr = '0;
        model_reset();
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op(1'b1, 1'b0, 12'h010, 12'h200, 1'b0);
        do_op(1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
        do_op(1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
        do_op(1'b1, 1'b0, 12'hFFF, 12'h123, 1'b0);
        do_op(1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
        do_op(1'b1, 1'b1, 12'h055, 12'h0AA, 1'b0);
        do_op(1'b1, 1'b0, 12'h300, 12'h400, 1'b1);
        for (int i = 0; i <= D; i++) begin
            do_op(1'b1, 1'b0, 12'(16 * i + 5), 12'(i + 12'h700), 1'b0);
        end
        do_op(1'b1, 1'b0, 12'h7FE, 12'h0F0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  12'($urandom), 12'($urandom), ($urandom_range(0, 3) == 0));
        end
        chk("queue_drained", 32'(exp_q.size()), 0);

        do_op(1'b1, 1'b0, 12'h020, 12'h040, 1'b0);
        @(negedge clk);
        ret_req = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        ret_req = 1'b0;
        model_reset();
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        do_op(1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
        do_op(1'b1, 1'b0, 12'h0AB, 12'h0CD, 1'b0);
        do_op(1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
        repeat (3) @(negedge clk);
        chk("final_queue", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
